// File: rtl/nibble_serial_adder.sv
// Serial wide adder: one 4-bit slice per clock through a single full_adder,
// ripple carry registered between slices, start/busy/done handshake.

module full_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] z,
    output logic       cout
);
    assign {cout, z} = 5'(x) + 5'(y) + 5'(cin);
endmodule

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [3:0]     fa_z;
    logic           fa_cout;
    logic [W-1:0]   acc_shift;

    full_adder u_fa (a_q[3:0], b_q[3:0], carry_q, fa_z, fa_cout);

    // New slice enters at the top so the last slice lands in the MSBs.
    assign acc_shift = {fa_z, acc_q[W-1:4]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift;
                carry_d = fa_cout;
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    sum_d   = acc_shift;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: timeline-based reference model checked every
// cycle, plus directed literal cases and a randomised sweep.

module tb_nibble_serial_adder;
    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the accept edge index and derives every output
    // from the distance to it; the result is plain (W+1)-bit arithmetic.
    int unsigned  edge_n = 0;
    int unsigned  t0 = 0;
    logic         m_active = 1'b0;
    logic         m_valid = 1'b0;
    logic [W:0]   m_pending = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_active = 1'b0;
            m_valid  = 1'b1;
            m_sum    = '0;
            m_cout   = 1'b0;
        end else if (m_valid) begin
            if (m_active && (edge_n - t0 == N))
                {m_cout, m_sum} = m_pending;
            if ((!m_active || (edge_n - t0 >= N + 2)) && start) begin
                m_active  = 1'b1;
                t0        = edge_n;
                m_pending = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 64'(busy), 64'(m_active && (edge_n - t0 < N)));
            chk("done", 64'(done), 64'(m_active && (edge_n - t0 == N)));
            chk("sum",  64'(sum),  64'(m_sum));
            chk("cout", 64'(cout), 64'(m_cout));
        end
    end

    // One start pulse, then wait for done while scrambling the operand inputs.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W:0] expv, input string name);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen = 0;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4 * N + 8; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_result"}, 64'({cout, sum}), 64'(expv));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(N));
    endtask

    initial begin
        int dones;
        int last_edge;
        logic [W-1:0] ra, rb;
        logic rc;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum_cout", 64'({cout, sum}), 64'd0);

        do_op(16'h1234, 16'h4321, 1'b0, 17'h05555, "basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "ripple");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "all_ones");

        // Start held during RUN must be ignored, not queued.
        @(posedge clk); #1;
        a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                start = 1'b0;
                chk("ignored_result", 64'({cout, sum}), 64'h00100);
                break;
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ignored_done_count", 64'(dones), 64'd1);
        chk("ignored_busy_after", 64'(busy), 64'd0);

        // Back-to-back operations with start held high.
        @(posedge clk); #1;
        a = 16'h0008; b = 16'h0008; cin = 1'b1; start = 1'b1;
        dones = 0;
        last_edge = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                chk("b2b_result", 64'({cout, sum}), 64'h00011);
                if (last_edge >= 0)
                    chk("b2b_period", 64'(int'(edge_n) - last_edge), 64'(N + 2));
                last_edge = int'(edge_n);
            end
        end
        chk("b2b_pulse_count", 64'(dones >= 6), 64'd1);
        start = 1'b0;
        repeat (2 * N + 4) @(negedge clk);

        // Reset during the second RUN cycle abandons the operation.
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sum_cout", 64'({cout, sum}), 64'd0);
        dones = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        do_op(16'h1111, 16'h2222, 1'b0, 17'h03333, "after_rst");

        // Randomised sweep with random idle gaps.
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(ra, rb, rc, (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc), "rand");
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
